// File: rtl/spi_cmd_bridge.sv
// SPI target that decodes host command frames into Pi-side bus reads and writes.
// Every SPI input is oversampled in the clk domain; nothing runs on SCLK.
module spi_cmd_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int WR_PULSE    = 4,
  parameter int RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [16:0] pi_addr,
  output logic [7:0]  pi_data,
  output logic        pi_write,
  output logic        pi_read,
  input  logic [7:0]  pi_rd_data,
  output logic        overrun
);

  localparam int WCW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam int RCW = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, DATA, DISCARD} state_t;

  state_t r_state, w_nextState;

  logic [SYNC_STAGES-1:0] r_csSync, r_sclkSync, r_mosiSync;
  logic                   r_sclkPrev;
  logic                   w_csN, w_sclk, w_mosi, w_sclkRise, w_sclkFall;

  logic [2:0]  r_bitCnt;
  logic [7:0]  r_rxShift;
  logic [7:0]  w_rxByte;
  logic        w_byteDone;

  logic [16:0]    r_addr;
  logic [7:0]     r_piData;
  logic           r_opRead;
  logic           r_wrStart, r_piWrite, r_incPend;
  logic [WCW-1:0] r_wrCnt;
  logic           r_rdStart, r_piRead;
  logic [RCW-1:0] r_rdCnt;
  logic [7:0]     r_txShift;
  logic           r_overrun;
  logic           w_busy, w_accessByte, w_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csSync   <= '1;
      r_sclkSync <= '0;
      r_mosiSync <= '0;
      r_sclkPrev <= 1'b0;
    end else begin
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
      r_sclkPrev <= w_sclk;
    end
  end

  assign w_csN      = r_csSync[SYNC_STAGES-1];
  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_sclkFall = ~w_sclk & r_sclkPrev;

  assign w_rxByte   = {r_rxShift[6:0], w_mosi};
  assign w_byteDone = w_sclkRise && !w_csN && (r_bitCnt == 3'd7);

  // Deasserting CS throws away any partial byte so the next frame starts aligned.
  always_ff @(posedge clk) begin
    if (reset || w_csN) begin
      r_bitCnt  <= 3'd0;
      r_rxShift <= 8'd0;
    end else if (w_sclkRise) begin
      r_bitCnt  <= r_bitCnt + 3'd1;
      r_rxShift <= w_rxByte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!w_csN) w_nextState = CMD;
      CMD:     if (w_byteDone) w_nextState = w_rxByte[7] ? ADDR_HI : DISCARD;
      ADDR_HI: if (w_byteDone) w_nextState = ADDR_LO;
      ADDR_LO: if (w_byteDone) w_nextState = DATA;
      default: w_nextState = r_state;
    endcase
    if (w_csN) w_nextState = IDLE;
  end

  // A bus access is still in flight from data load until the post-write address bump or read capture.
  assign w_busy       = r_wrStart | r_piWrite | r_incPend | r_rdStart | r_piRead | (r_rdCnt != '0);
  assign w_accessByte = w_byteDone && ((r_state == ADDR_LO && r_opRead) || r_state == DATA);
  assign w_drop       = w_accessByte && w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= 17'd0;
      r_piData  <= 8'd0;
      r_opRead  <= 1'b0;
      r_wrStart <= 1'b0;
      r_piWrite <= 1'b0;
      r_incPend <= 1'b0;
      r_wrCnt   <= '0;
      r_rdStart <= 1'b0;
      r_piRead  <= 1'b0;
      r_rdCnt   <= '0;
      r_txShift <= 8'd0;
      r_overrun <= 1'b0;
    end else begin
      r_wrStart <= 1'b0;
      r_rdStart <= 1'b0;
      r_incPend <= 1'b0;

      // Data was loaded one cycle earlier, so it is settled before pi_write rises.
      if (r_wrStart) begin
        r_piWrite <= 1'b1;
        r_wrCnt   <= WCW'(WR_PULSE - 1);
      end else if (r_piWrite) begin
        if (r_wrCnt == '0) begin
          r_piWrite <= 1'b0;
          r_incPend <= 1'b1;
        end else begin
          r_wrCnt <= r_wrCnt - WCW'(1);
        end
      end
      if (r_incPend) r_addr <= r_addr + 17'd1;

      r_piRead <= r_rdStart;
      if (r_rdStart)            r_rdCnt <= RCW'(RD_LATENCY);
      else if (r_rdCnt != '0)   r_rdCnt <= r_rdCnt - RCW'(1);

      // No shift on the fall that ends a byte, so a freshly captured bit 7 survives.
      if (w_sclkFall && !w_csN && r_bitCnt != 3'd0) r_txShift <= {r_txShift[6:0], 1'b0};
      if (r_rdCnt == RCW'(1)) r_txShift <= pi_rd_data;

      if (w_byteDone) begin
        case (r_state)
          CMD: begin
            if (w_rxByte[7]) begin
              r_opRead   <= w_rxByte[6];
              r_addr[16] <= w_rxByte[0];
            end
          end
          ADDR_HI: r_addr[15:8] <= w_rxByte;
          ADDR_LO: begin
            r_addr[7:0] <= w_rxByte;
            if (r_opRead && !w_busy) r_rdStart <= 1'b1;
          end
          DATA: begin
            if (!w_busy) begin
              if (r_opRead) begin
                r_addr    <= r_addr + 17'd1;
                r_rdStart <= 1'b1;
              end else begin
                r_piData  <= w_rxByte;
                r_wrStart <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  always_comb begin
    spi_miso = 1'b0;
    if (r_state == DATA && r_opRead) spi_miso = r_txShift[7];
  end

  assign pi_addr  = r_addr;
  assign pi_data  = r_piData;
  assign pi_write = r_piWrite;
  assign pi_read  = r_piRead;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed bench for spi_cmd_bridge: a frame table driven at SCLK=clk/8 plus
// hand-written abort and reset-mid-write sequences.
module tb_spi_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [16:0] pi_addr;
  logic [7:0]  pi_data;
  logic        pi_write;
  logic        pi_read;
  logic [7:0]  pi_rd_data;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lastRiseCyc = 0;

  spi_cmd_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .pi_addr    (pi_addr),
    .pi_data    (pi_data),
    .pi_write   (pi_write),
    .pi_read    (pi_read),
    .pi_rd_data (pi_rd_data),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register model: each address reads back its own low byte.
  assign pi_rd_data = pi_addr[7:0];

  typedef struct {
    logic [0:5][7:0]  bytes;
    int               nBytes;
    int               nWr;
    logic [0:1][16:0] wrAddr;
    logic [0:1][7:0]  wrData;
    int               nRd;
    logic [0:2][16:0] rdAddr;
    logic [0:5][7:0]  miso;
    logic [16:0]      endAddr;
  } vec_t;

  logic [16:0] qWrAddr[$];
  logic [7:0]  qWrData[$];
  int          qWrWidth[$];
  bit          qWrStable[$];
  int          qWrLat[$];
  logic [16:0] qRdAddr[$];
  logic [7:0]  rxBytes[0:5];

  logic        prevWrite = 1'b0, prevRead = 1'b0;
  logic [16:0] prevAddr = '0, mAddr = '0;
  logic [7:0]  prevData = '0, mData = '0;
  int          mWidth = 0, mLat = 0;
  bit          mStable = 1'b0, bothHigh = 1'b0, readLong = 1'b0;

  // Bus monitor: records each write pulse with its width, latency and hold window.
  always @(negedge clk) begin
    prevWrite <= pi_write;
    prevRead  <= pi_read;
    prevAddr  <= pi_addr;
    prevData  <= pi_data;
    if (pi_write && !prevWrite) begin
      mAddr   <= pi_addr;
      mData   <= pi_data;
      mWidth  <= 1;
      mStable <= (prevAddr == pi_addr) && (prevData == pi_data);
      mLat    <= cyc - lastRiseCyc;
    end else if (pi_write) begin
      mWidth <= mWidth + 1;
      if (pi_addr != mAddr || pi_data != mData) mStable <= 1'b0;
    end else if (prevWrite) begin
      qWrAddr.push_back(mAddr);
      qWrData.push_back(mData);
      qWrWidth.push_back(mWidth);
      qWrStable.push_back(mStable && pi_addr == mAddr && pi_data == mData);
      qWrLat.push_back(mLat);
    end
    if (pi_read && !prevRead) qRdAddr.push_back(pi_addr);
    if (pi_read && prevRead)  readLong <= 1'b1;
    if (pi_read && pi_write)  bothHigh <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearQueues();
    qWrAddr.delete(); qWrData.delete(); qWrWidth.delete();
    qWrStable.delete(); qWrLat.delete(); qRdAddr.delete();
  endtask

  task automatic halfPeriod();
    repeat (4) @(negedge clk);
  endtask

  task automatic spiBit(input logic b, output logic m);
    spi_mosi = b;
    halfPeriod();
    m = spi_miso;
    spi_sclk = 1'b1;
    lastRiseCyc = cyc;
    halfPeriod();
    spi_sclk = 1'b0;
  endtask

  task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spiBit(tx[i], rx[i]);
  endtask

  task automatic csLow();
    spi_cs_n = 1'b0;
    halfPeriod();
  endtask

  task automatic csHigh();
    halfPeriod();
    spi_cs_n = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    clearQueues();
    for (int i = 0; i < 6; i++) rxBytes[i] = 8'h00;
    csLow();
    for (int i = 0; i < v.nBytes; i++) spiByte(v.bytes[i], rxBytes[i]);
    csHigh();
  endtask

  task automatic checkFrame(input vec_t v, input string tag);
    checkOutput($sformatf("%s numWrites", tag), 32'(qWrAddr.size()), 32'(v.nWr));
    for (int i = 0; i < v.nWr; i++) begin
      if (i < qWrAddr.size()) begin
        checkOutput($sformatf("%s wrAddr%0d", tag, i), 32'(qWrAddr[i]), 32'(v.wrAddr[i]));
        checkOutput($sformatf("%s wrData%0d", tag, i), 32'(qWrData[i]), 32'(v.wrData[i]));
        checkOutput($sformatf("%s wrWidth%0d", tag, i), 32'(qWrWidth[i]), 32'd4);
        checkOutput($sformatf("%s wrStable%0d", tag, i), 32'(qWrStable[i]), 32'd1);
        checkOutput($sformatf("%s wrLatencyOk%0d", tag, i), 32'(qWrLat[i] <= 5), 32'd1);
      end
    end
    checkOutput($sformatf("%s numReads", tag), 32'(qRdAddr.size()), 32'(v.nRd));
    for (int i = 0; i < v.nRd; i++) begin
      if (i < qRdAddr.size())
        checkOutput($sformatf("%s rdAddr%0d", tag, i), 32'(qRdAddr[i]), 32'(v.rdAddr[i]));
    end
    for (int i = 0; i < v.nBytes; i++)
      checkOutput($sformatf("%s misoByte%0d", tag, i), 32'(rxBytes[i]), 32'(v.miso[i]));
    checkOutput($sformatf("%s endAddr", tag), 32'(pi_addr), 32'(v.endAddr));
    checkOutput($sformatf("%s overrun", tag), 32'(overrun), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t v;
    logic [7:0] dummy;
    logic       dummyBit;
    bit         found;

    vecs[0] = '{{8'h80, 8'hE8, 8'h03, 8'hFE, 8'h00, 8'h00}, 4, 1, {17'h0E803, 17'h0}, {8'hFE, 8'h00},
                0, {17'h0, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h0E804};
    vecs[1] = '{{8'h81, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h00}, 5, 2, {17'h1FFFF, 17'h00000}, {8'h11, 8'h22},
                0, {17'h0, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h00001};
    vecs[2] = '{{8'hC0, 8'hE8, 8'h12, 8'h00, 8'h00, 8'h00}, 5, 0, {17'h0, 17'h0}, {8'h00, 8'h00},
                3, {17'h0E812, 17'h0E813, 17'h0E814}, {8'h00, 8'h00, 8'h00, 8'h12, 8'h13, 8'h00}, 17'h0E814};
    vecs[3] = '{{8'h00, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00}, 4, 0, {17'h0, 17'h0}, {8'h00, 8'h00},
                0, {17'h0, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h0E814};
    vecs[4] = '{{8'h7F, 8'hFF, 8'h01, 8'h02, 8'h00, 8'h00}, 4, 0, {17'h0, 17'h0}, {8'h00, 8'h00},
                0, {17'h0, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h0E814};
    vecs[5] = '{{8'hC1, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00}, 3, 0, {17'h0, 17'h0}, {8'h00, 8'h00},
                1, {17'h10005, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h10005};
    vecs[6] = '{{8'h80, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00}, 3, 0, {17'h0, 17'h0}, {8'h00, 8'h00},
                0, {17'h0, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h00007};
    vecs[7] = '{{8'hC1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, 4, 0, {17'h0, 17'h0}, {8'h00, 8'h00},
                2, {17'h1FFFF, 17'h00000, 17'h0}, {8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00}, 17'h00000};

    repeat (4) @(negedge clk);
    checkOutput("resetPiWrite", 32'(pi_write), 32'd0);
    checkOutput("resetPiRead", 32'(pi_read), 32'd0);
    checkOutput("resetPiAddr", 32'(pi_addr), 32'd0);
    checkOutput("resetPiData", 32'(pi_data), 32'd0);
    checkOutput("resetMiso", 32'(spi_miso), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 8; n++) begin
      applyStimulus(vecs[n]);
      checkFrame(vecs[n], $sformatf("vec%0d", n));
    end

    // Write frame aborted five bits into the first data byte.
    clearQueues();
    csLow();
    spiByte(8'h80, dummy);
    spiByte(8'h00, dummy);
    spiByte(8'h09, dummy);
    for (int i = 0; i < 5; i++) spiBit(1'b1, dummyBit);
    csHigh();
    checkOutput("abortNoWrite", 32'(qWrAddr.size()), 32'd0);
    checkOutput("abortAddr", 32'(pi_addr), 32'h00009);
    v = '{{8'h80, 8'h00, 8'h01, 8'hAA, 8'h00, 8'h00}, 4, 1, {17'h00001, 17'h0}, {8'hAA, 8'h00},
          0, {17'h0, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h00002};
    applyStimulus(v);
    checkFrame(v, "afterAbort");

    // Reset landing in the middle of a write pulse.
    clearQueues();
    csLow();
    spiByte(8'h80, dummy);
    spiByte(8'h12, dummy);
    spiByte(8'h34, dummy);
    spiByte(8'h56, dummy);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (pi_write) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("rstSawWrite", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstMidWrite pi_write", 32'(pi_write), 32'd0);
    checkOutput("rstMidWrite pi_addr", 32'(pi_addr), 32'd0);
    checkOutput("rstMidWrite pi_data", 32'(pi_data), 32'd0);
    checkOutput("rstMidWrite pi_read", 32'(pi_read), 32'd0);
    checkOutput("rstMidWrite miso", 32'(spi_miso), 32'd0);
    reset = 1'b0;
    csHigh();
    v = '{{8'h80, 8'h00, 8'h02, 8'h5A, 8'h00, 8'h00}, 4, 1, {17'h00002, 17'h0}, {8'h5A, 8'h00},
          0, {17'h0, 17'h0, 17'h0}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 17'h00003};
    applyStimulus(v);
    checkFrame(v, "afterReset");

    checkOutput("neverBothHigh", 32'(bothHigh), 32'd0);
    checkOutput("readOneCycle", 32'(readLong), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_bridge.md
Name: spi_cmd_bridge

Overview:
SPI target that receives command frames from the Raspberry Pi / RP2040 host and turns them into accesses on the Pi-side bus (pi_addr, pi_data, pi_write, pi_read). It sits directly upstream of the keyboard matrix cache, which latches pi_data on the falling edge of pi_write for pi_addr $E800–$E809, and of any other Pi-writable register. All SPI inputs are oversampled in the system clock domain. No logic runs on SCLK.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizers on spi_cs_n, spi_sclk and spi_mosi (minimum 2).
WR_PULSE, 4, number of clk cycles pi_write is held high per write (minimum 1).
RD_LATENCY, 2, number of clk cycles from pi_read rising to pi_rd_data being sampled.

Ports:
clk  input  1  system clock; sole clock of the block.
reset  input  1  synchronous, active-high reset.
spi_cs_n  input  1  SPI chip select, active low; asynchronous to clk.
spi_sclk  input  1  SPI clock, mode 0; maximum frequency is clk/8.
spi_mosi  input  1  SPI data from the host, MSB first.
spi_miso  output  1  SPI data to the host. Driven 0 outside the read-data phase; tristating is done at the top level.
pi_addr  output  17  bus address.
pi_data  output  8  write data.
pi_write  output  1  write strobe. Consumers capture on its falling edge.
pi_read  output  1  read strobe.
pi_rd_data  input  8  read data returned by the addressed register.
overrun  output  1  sticky error flag: a byte was dropped. Cleared only by reset.

Behaviour:
- Reset values: pi_addr=0, pi_data=0, pi_write=0, pi_read=0, spi_miso=0, overrun=0, FSM=IDLE. Reset overrides everything, including a strobe in progress: pi_write drops in the same cycle.
- Synchronizers: spi_cs_n, spi_sclk and spi_mosi each pass through SYNC_STAGES flops.
- Edge detection: SCLK rise and fall are detected on the synchronized signal. MOSI is sampled on the detected rise. MISO is updated on the detected fall.
- Frame layout:
  - byte0 = command: [7:6] opcode (2'b10 write, 2'b11 read, anything else no-op); [5:1] ignored; [0] addr[16].
  - byte1 = addr[15:8].
  - byte2 = addr[7:0].
  - byte3 onward = data bytes.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DATA, DISCARD.
  - IDLE -> CMD when cs_n is low.
  - CMD -> ADDR_HI on a valid opcode; CMD -> DISCARD on a no-op.
  - ADDR_HI -> ADDR_LO -> DATA as each byte completes.
  - DATA loops on itself for every subsequent byte.
  - Any state -> IDLE on synchronized cs_n high. The partial byte and bit counter are discarded.
- Write: when each DATA byte completes, load pi_data and assert pi_write.
  - pi_write asserts within 2 clk of the 8th sampling edge and stays high exactly WR_PULSE cycles.
  - pi_addr and pi_data are stable from 1 cycle before the rise until 1 cycle after the fall.
  - pi_addr then increments by 1, modulo 2^17 (1FFFF wraps to 00000).
- Read: on completion of byte2, pulse pi_read for 1 cycle and capture pi_rd_data RD_LATENCY cycles after the rise into the MISO shift register.
  - The shifted value is transmitted MSB first during the next byte. Bit 7 is presented before the first SCLK rise of that byte.
  - On completion of each DATA byte in a read frame, pi_addr increments (wrap as above) and the next read is issued immediately.
  - MOSI content during read data bytes is ignored.
- Busy conflict: if a byte completes while a write pulse or read capture is still pending, that byte is dropped and overrun is set. Unreachable at SCLK <= clk/8, but the behaviour is required.
- CS deassert while pi_write is high: the pulse completes its full WR_PULSE with addr and data held. A pending read capture also completes.
- No-op / DISCARD: no bus activity for the remainder of the frame; MISO stays 0.
- Frames shorter than 4 bytes perform no access, except that a read issues pi_read once byte2 completes.
- pi_write and pi_read are never high in the same cycle.

Test Plan:
- Write frame 80 E8 03 FE at SCLK=clk/8 -> one pi_write pulse 4 cycles wide with pi_addr=0E803 and pi_data=FE stable across the falling edge; pi_addr ends at 0E804.
- Burst write 81 FF FF 11 22 -> writes 11 to 1FFFF, then 22 to 00000 (wrap); exactly 2 pulses.
- Read frame C0 E8 12 00 with pi_rd_data model returning {addr[7:0]} -> pi_read pulse at addr 0E812; MISO returns 12. A following 00 byte returns 13 (auto-increment read).
- CS raised after 5 bits of byte3 in a write frame -> no pi_write; next frame 80 00 01 AA writes AA to 00001 correctly.
- Opcode 00 frame of 4 bytes -> no pi_write/pi_read; MISO 0 throughout; overrun stays 0.
- Reset asserted while pi_write is high -> pi_write, pi_addr and pi_data are 0 the next cycle; FSM in IDLE; a subsequent frame behaves normally.
